inst_mem_fetch: RTL and testbench

INST_MEM_FETCH -- requirements
Module: inst_mem_fetch

---
 rtl/inst_mem_fetch.sv | 82 ++++++++
 tb/tb_inst_mem_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_fetch.sv
// Instruction memory with a one-entry response register and a program-load write port.
// Latency: 1 cycle from request acceptance to rsp_valid. Backpressure: req_ready drops while a response is held without rsp_ready, or during flush.
module inst_mem_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0]    prog_data
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]        index;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    fetch_err;
    logic                    accept;

    assign index        = req_addr[IDX_W+1:2];
    assign misaligned   = |req_addr[1:0];
    // Any bit above the word index means the word address is at or beyond DEPTH.
    assign out_of_range = |(req_addr >> (IDX_W + 2));
    assign fetch_err    = misaligned || out_of_range;

    assign rsp_valid = (state == FULL);
    assign req_ready = !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Memory is deliberately left out of reset; loads are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (flush) begin
                        state <= EMPTY;
                    end else if (rsp_ready && !accept) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            // The read samples mem before this edge's program write lands.
            if (accept) begin
                rsp_data <= fetch_err ? NOP_WORD : mem[index];
                rsp_err  <= fetch_err;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch with a reference memory and an expected-response queue.
module tb_inst_mem_fetch;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int IW    = $clog2(DEPTH);

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          flush;
    logic          prog_we;
    logic [IW-1:0] prog_addr;
    logic [DW-1:0] prog_data;

    logic [DW-1:0] mdl [DEPTH];
    rsp_t          q [$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] prog_words [6];

    inst_mem_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(32'h00000000)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    function automatic void check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    function automatic rsp_t model_fetch(logic [AW-1:0] addr);
        rsp_t r;
        r.err  = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
        r.data = r.err ? 32'h00000000 : mdl[addr[IW+1:2]];
        return r;
    endfunction

    // One clock: handshake evaluated at the falling edge, reference memory updated at the rising edge.
    task automatic step();
        logic exp_ready;
        rsp_t exp;
        @(negedge clk);
        if (!reset_n) begin
            q.delete();
        end else begin
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() != 0});
            exp_ready = !flush && (q.size() == 0 || rsp_ready);
            check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
            if (flush) begin
                q.delete();
            end else if (q.size() != 0 && rsp_ready) begin
                exp = q.pop_front();
                check("rsp_data", rsp_data, exp.data);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, exp.err});
            end
            if (req_valid && exp_ready) begin
                q.push_back(model_fetch(req_addr));
            end
        end
        @(posedge clk);
        if (reset_n && prog_we) mdl[prog_addr] = prog_data;
        #1;
    endtask

    task automatic fetch_run(input int n, input int stride);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * stride);
            step();
        end
        req_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        prog_words[0] = 32'h00A60820;
        prog_words[1] = 32'h21420002;
        prog_words[2] = 32'h21830001;
        prog_words[3] = 32'h008A2020;
        prog_words[4] = 32'h02852822;
        prog_words[5] = 32'h03083023;

        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        step();
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        reset_n = 1'b1;
        step();

        // Program load
        for (int i = 0; i < 6; i++) begin
            prog_we = 1'b1; prog_addr = IW'(i); prog_data = prog_words[i];
            step();
        end
        prog_we = 1'b0;

        // Back-to-back fetches of the six words
        fetch_run(6, 4);

        // Stall with a held response
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd4;
        step();
        req_addr = 32'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall rsp_data", rsp_data, 32'h21420002);
            check("stall req_ready", {31'b0, req_ready}, 32'd0);
            check("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();

        // Misaligned and out-of-range fetches
        req_valid = 1'b1; req_addr = 32'd6;
        step();
        req_addr = 32'(4 * DEPTH);
        step();
        req_valid = 1'b0;
        step();
        step();

        // Flush while FULL with a request pending
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd12;
        step();
        flush = 1'b1; req_addr = 32'd16;
        step();
        check("flush rsp_valid", {31'b0, rsp_valid}, 32'd0);
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        step();
        check("post-flush rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // Program write colliding with a fetch of the same word
        req_valid = 1'b1; req_addr = 32'd8;
        prog_we = 1'b1; prog_addr = IW'(2); prog_data = 32'hFFFFFFFF;
        step();
        check("collide old word", rsp_data, 32'h21830001);
        prog_we = 1'b0;
        step();
        check("refetch new word", rsp_data, 32'hFFFFFFFF);
        req_valid = 1'b0;
        step();
        step();

        // Asynchronous reset in the middle of a held response
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd20;
        step();
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("async rsp_data", rsp_data, 32'd0);
        prog_we = 1'b1; prog_addr = '0; prog_data = 32'h0BAD0BAD;
        req_valid = 1'b1; req_addr = 32'd0;
        step();
        check("in-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        prog_we = 1'b0; req_valid = 1'b0;
        reset_n = 1'b1; rsp_ready = 1'b1;
        fetch_run(6, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
